mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 111 +++++++++++
 tb/tb_mem_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch read port and a data read/write port onto one single-port synchronous RAM.
// Latency: grant is combinational in the request cycle; read data returns one cycle after the grant.
// Backpressure: a requester holds req/addr/we/wdata until gnt; one RAM access issues per cycle.
// Optional feature macro: ROUND_ROBIN_EN (alternate priority on conflict; otherwise data port always wins).
module mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // RD_F / RD_D mark that the RAM output in this cycle belongs to that port.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD_F = 2'd1,
        RD_D = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   prefer_d;

`ifdef ROUND_ROBIN_EN
    // ptr = 0: data port wins the next conflict; ptr = 1: fetch port wins.
    logic ptr;
    logic ptr_nxt;

    // Pointer remembers which port was granted last; reset leaves data preferred.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= 1'b0;
        end else begin
            ptr <= ptr_nxt;
        end
    end

    assign prefer_d = ~ptr;
`else
    assign prefer_d = 1'b1;
`endif

    // State register: an in-flight read is dropped asynchronously by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Grant selection, RAM command and next state; a new grant is allowed in every state.
    always_comb begin
        f_gnt     = 1'b0;
        d_gnt     = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        state_nxt = IDLE;
`ifdef ROUND_ROBIN_EN
        ptr_nxt   = ptr;
`endif
        if (!rst) begin
            if (d_req && (!f_req || prefer_d)) begin
                d_gnt    = 1'b1;
                mem_addr = d_addr;
`ifdef ROUND_ROBIN_EN
                ptr_nxt  = 1'b1;
`endif
                if (d_we) begin
                    mem_we    = 1'b1;
                    mem_wdata = d_wdata;
                end else begin
                    state_nxt = RD_D;
                end
            end else if (f_req) begin
                f_gnt     = 1'b1;
                mem_addr  = f_addr;
                state_nxt = RD_F;
`ifdef ROUND_ROBIN_EN
                ptr_nxt   = 1'b0;
`endif
            end
        end
    end

    // Response side: the registered RAM output is routed straight through, qualified by state.
    always_comb begin
        f_rvalid = (state == RD_F);
        d_rvalid = (state == RD_D);
        f_rdata  = mem_rdata;
        d_rdata  = mem_rdata;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with a behavioural single-port synchronous RAM.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Expected values are hand-derived constants per step.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        f_req;
    logic [15:0] f_addr;
    logic        f_gnt;
    logic        f_rvalid;
    logic [15:0] f_rdata;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [15:0] d_rdata;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    // Bench-side preload port into the RAM model
    logic        ld_en;
    logic [15:0] ld_addr;
    logic [15:0] ld_dat;

    int n_chk  = 0;
    int n_pass = 0;

    logic [15:0] ram [0:65535];

    mem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .f_req     (f_req),
        .f_addr    (f_addr),
        .f_gnt     (f_gnt),
        .f_rvalid  (f_rvalid),
        .f_rdata   (f_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM, registered read, read-before-write on the same address
    always @(posedge clk) begin
        if (ld_en) begin
            ram[ld_addr] <= ld_dat;
        end else if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
        mem_rdata <= ram[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        f_req   = 1'b0;
        f_addr  = 16'h0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = 16'h0;
        d_wdata = 16'h0;
    endtask

    task automatic preload(input logic [15:0] a, input logic [15:0] v);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_dat  = v;
        tick();
        ld_en   = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".f_gnt"},     {31'd0, f_gnt},    32'd0);
        check({tag, ".d_gnt"},     {31'd0, d_gnt},    32'd0);
        check({tag, ".f_rvalid"},  {31'd0, f_rvalid}, 32'd0);
        check({tag, ".d_rvalid"},  {31'd0, d_rvalid}, 32'd0);
        check({tag, ".mem_we"},    {31'd0, mem_we},   32'd0);
        check({tag, ".mem_addr"},  {16'd0, mem_addr}, 32'd0);
        check({tag, ".mem_wdata"}, {16'd0, mem_wdata}, 32'd0);
    endtask

    logic exp_d;
    logic prev_d;

    initial begin
        rst   = 1'b1;
        ld_en = 1'b0;
        ld_addr = 16'h0;
        ld_dat  = 16'h0;
        idle_inputs();
        // Requests held high during reset must not be granted
        f_req  = 1'b1;
        f_addr = 16'h0010;
        d_req  = 1'b1;
        d_we   = 1'b1;
        d_addr = 16'h0020;
        d_wdata = 16'hFFFF;
        sample();
        check_reset_outputs("reset");

        preload(16'h0010, 16'hBEEF);
        preload(16'h0300, 16'h5555);
        for (int i = 0; i < 4; i++) begin
            preload(16'(i), 16'hA000 + 16'(i));
        end
        idle_inputs();
        tick();
        rst = 1'b0;
        tick();

        // Idle: no request, no grant, RAM bus parked at zero
        sample();
        check("idle.f_gnt",    {31'd0, f_gnt},    32'd0);
        check("idle.d_gnt",    {31'd0, d_gnt},    32'd0);
        check("idle.mem_addr", {16'd0, mem_addr}, 32'd0);
        check("idle.mem_we",   {31'd0, mem_we},   32'd0);

        // Fetch-only read of 0x0010
        tick();
        f_req  = 1'b1;
        f_addr = 16'h0010;
        sample();
        check("fetch.f_gnt",    {31'd0, f_gnt},    32'd1);
        check("fetch.d_gnt",    {31'd0, d_gnt},    32'd0);
        check("fetch.mem_addr", {16'd0, mem_addr}, 32'h0010);
        check("fetch.mem_we",   {31'd0, mem_we},   32'd0);
        tick();
        idle_inputs();
        sample();
        check("fetch.f_rvalid", {31'd0, f_rvalid}, 32'd1);
        check("fetch.f_rdata",  {16'd0, f_rdata},  32'hBEEF);
        check("fetch.d_rvalid", {31'd0, d_rvalid}, 32'd0);
        tick();
        sample();
        check("fetch.f_rvalid_once", {31'd0, f_rvalid}, 32'd0);

        // Data write 0x0200 <= 0x1234, then read it back
        d_req = 1'b1;
        d_we  = 1'b1;
        d_addr = 16'h0200;
        d_wdata = 16'h1234;
        sample();
        check("wr.d_gnt",     {31'd0, d_gnt},     32'd1);
        check("wr.mem_we",    {31'd0, mem_we},    32'd1);
        check("wr.mem_addr",  {16'd0, mem_addr},  32'h0200);
        check("wr.mem_wdata", {16'd0, mem_wdata}, 32'h1234);
        tick();
        d_we = 1'b0;
        d_wdata = 16'h0;
        sample();
        check("rd.d_gnt",       {31'd0, d_gnt},    32'd1);
        check("rd.mem_we",      {31'd0, mem_we},   32'd0);
        check("wr.no_d_rvalid", {31'd0, d_rvalid}, 32'd0);
        tick();
        idle_inputs();
        sample();
        check("rd.d_rvalid", {31'd0, d_rvalid}, 32'd1);
        check("rd.d_rdata",  {16'd0, d_rdata},  32'h1234);
        check("rd.f_rvalid", {31'd0, f_rvalid}, 32'd0);

        // Read 0x0300 then write it next cycle: pending read returns the old value
        tick();
        d_req = 1'b1;
        d_we  = 1'b0;
        d_addr = 16'h0300;
        tick();
        d_we  = 1'b1;
        d_wdata = 16'h6666;
        sample();
        check("raw.d_gnt",    {31'd0, d_gnt},    32'd1);
        check("raw.mem_we",   {31'd0, mem_we},   32'd1);
        check("raw.d_rvalid", {31'd0, d_rvalid}, 32'd1);
        check("raw.d_rdata",  {16'd0, d_rdata},  32'h5555);
        tick();
        d_we = 1'b0;
        d_wdata = 16'h0;
        tick();
        idle_inputs();
        sample();
        check("raw.new_rdata", {16'd0, d_rdata}, 32'h6666);

        // Conflict, both held 4 cycles, starting from a freshly reset pointer
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        f_req  = 1'b1;
        f_addr = 16'h0010;
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 16'h0200;
        prev_d = 1'b0;
        for (int i = 0; i < 4; i++) begin
`ifdef ROUND_ROBIN_EN
            exp_d = (i % 2 == 0);
`else
            exp_d = 1'b1;
`endif
            sample();
            check($sformatf("conf%0d.d_gnt", i), {31'd0, d_gnt}, {31'd0, exp_d});
            check($sformatf("conf%0d.f_gnt", i), {31'd0, f_gnt}, {31'd0, ~exp_d});
            if (i > 0) begin
                check($sformatf("conf%0d.d_rvalid", i), {31'd0, d_rvalid}, {31'd0, prev_d});
                check($sformatf("conf%0d.f_rvalid", i), {31'd0, f_rvalid}, {31'd0, ~prev_d});
            end
            prev_d = exp_d;
            tick();
        end
        idle_inputs();

        // Back-to-back fetch reads of 0x0000..0x0003
        tick();
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                f_req  = 1'b1;
                f_addr = 16'(i);
            end else begin
                idle_inputs();
            end
            sample();
            if (i < 4) begin
                check($sformatf("b2b%0d.f_gnt", i), {31'd0, f_gnt}, 32'd1);
            end
            if (i > 0) begin
                check($sformatf("b2b%0d.f_rvalid", i), {31'd0, f_rvalid}, 32'd1);
                check($sformatf("b2b%0d.f_rdata", i), {16'd0, f_rdata}, 32'hA000 + 32'(i - 1));
            end
            tick();
        end

        // Reset in the cycle after a data read grant
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 16'h0010;
        sample();
        check("rstmid.d_gnt", {31'd0, d_gnt}, 32'd1);
        tick();
        rst = 1'b1;
        idle_inputs();
        sample();
        check_reset_outputs("rstmid");
        tick();
        rst = 1'b0;
        sample();
        check("rstmid.no_d_rvalid", {31'd0, d_rvalid}, 32'd0);
        tick();
        f_req  = 1'b1;
        f_addr = 16'h0010;
        sample();
        check("rstmid.f_gnt", {31'd0, f_gnt}, 32'd1);
        tick();
        idle_inputs();
        sample();
        check("rstmid.f_rvalid", {31'd0, f_rvalid}, 32'd1);
        check("rstmid.f_rdata",  {16'd0, f_rdata},  32'hBEEF);

        tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
